// File: rtl/core_types_pkg.sv
// Shared decode types for the decode/issue stage: opcodes, formats,
// ALU op bundle, source-use table and the decoded-op struct.
package core_types_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RI     = 7'b0010011;
  localparam logic [6:0] OPC_RR     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic       aux_sel;
  } alu_op_t;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } rs_use_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] opA;
    logic [CORE_XLEN-1:0] opB;
    alu_op_t              alu_op;
    logic [4:0]           rd;
    logic                 rf_wr_en;
    logic [CORE_XLEN-1:0] pc;
    logic                 illegal;
  } decode_out_t;

  function automatic fmt_e fmt_of(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:          f = FMT_U;
      OPC_JAL:                     f = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_RI:  f = FMT_I;
      OPC_BRANCH:                  f = FMT_B;
      OPC_STORE:                   f = FMT_S;
      OPC_RR:                      f = FMT_R;
      default:                     f = FMT_X;
    endcase
    return f;
  endfunction

  function automatic rs_use_t rs_use(input logic [6:0] opc);
    rs_use_t u;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_RI:   u = '{rs1: 1'b1, rs2: 1'b0};
      OPC_BRANCH, OPC_STORE, OPC_RR: u = '{rs1: 1'b1, rs2: 1'b1};
      default:                      u = '{rs1: 1'b0, rs2: 1'b0};
    endcase
    return u;
  endfunction

  function automatic logic [31:0] imm_of(
    input logic [31:0] i,
    input fmt_e        f
  );
    logic [31:0] v;
    case (f)
      FMT_I: v = {{20{i[31]}}, i[31:20]};
      FMT_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B: v = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      FMT_U: v = {i[31:12], 12'b0};
      FMT_J: v = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch / register-file / execute / writeback bundle of decode_issue.
// master = surrounding pipeline, slave = decode stage.
interface decode_issue_if
  import core_types_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);
  logic            f_valid;
  logic            f_ready;
  logic [31:0]     f_instr;
  logic [XLEN-1:0] f_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            x_valid;
  logic            x_ready;
  logic [XLEN-1:0] x_opA;
  logic [XLEN-1:0] x_opB;
  alu_op_t         x_alu_op;
  logic [4:0]      x_rd;
  logic            x_rf_wr_en;
  logic [XLEN-1:0] x_pc;
  logic            x_illegal;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  modport master (
    output f_valid, f_instr, f_pc,
    output rs1_data, rs2_data, x_ready,
    output wb_valid, wb_rd, wb_data, flush,
    input  f_ready, rs1, rs2,
    input  x_valid, x_opA, x_opB, x_alu_op,
    input  x_rd, x_rf_wr_en, x_pc, x_illegal
  );

  modport slave (
    input  f_valid, f_instr, f_pc,
    input  rs1_data, rs2_data, x_ready,
    input  wb_valid, wb_rd, wb_data, flush,
    output f_ready, rs1, rs2,
    output x_valid, x_opA, x_opB, x_alu_op,
    output x_rd, x_rf_wr_en, x_pc, x_illegal
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters and RAW/WAW hazard detect.
// DECODE_WB_BYPASS_EN: same-cycle writeback clears a last-pending RAW.
module decode_scoreboard
  import core_types_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 3,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_use,
  input  logic       rs2_use,
  input  logic [4:0] rd,
  input  logic       wr_en,
  input  logic       accept,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       kill,
  input  logic [4:0] kill_rd,
  output logic       hazard
);

  logic [CW-1:0] cnt [NUM_REGS];

  logic [CW-1:0] c1, c2, cd;
  logic          h1, h2, hw;

  always_comb begin
    c1 = (rs1 != 5'd0) ? cnt[rs1] : '0;
    c2 = (rs2 != 5'd0) ? cnt[rs2] : '0;
    cd = (rd  != 5'd0) ? cnt[rd]  : '0;
    h1 = rs1_use && (c1 != '0);
    h2 = rs2_use && (c2 != '0);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid && wb_rd == rs1 && c1 == CW'(1))
      h1 = 1'b0;
    if (wb_valid && wb_rd == rs2 && c2 == CW'(1))
      h2 = 1'b0;
`endif
    hw = wr_en && (cd == CW'(MAX_INFLIGHT));
    hazard = h1 || h2 || hw;
  end

  // Net of +accept, -writeback, -flush, floored at zero.
  function automatic logic [CW-1:0] next_cnt(
    input logic [CW-1:0] c,
    input logic          inc,
    input logic          dwb,
    input logic          dkl
  );
    int n;
    int s;
    n = int'(c) + int'(inc);
    s = int'(dwb) + int'(dkl);
    return (n > s) ? CW'(n - s) : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++)
        cnt[r] <= next_cnt(
          cnt[r],
          accept && wr_en && rd == 5'(r),
          wb_valid && wb_rd == 5'(r),
          kill && kill_rd == 5'(r));
    end
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode-and-issue stage: combinational decode, scoreboard, X reg.
// DECODE_WB_BYPASS_EN: take wb_data for a source retiring this cycle.
module decode_issue
  import core_types_pkg::*;
#(
  parameter int XLEN         = CORE_XLEN,
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_issue_if.slave bus
);

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  fmt_e        fmt;
  rs_use_t     use_rs;
  logic [31:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  decode_out_t dec;
  logic        hazard, accept, kill;

  assign instr   = bus.f_instr;
  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign rd      = instr[11:7];
  assign bus.rs1 = instr[19:15];
  assign bus.rs2 = instr[24:20];

  always_comb begin
    rs1_val = bus.rs1_data;
    rs2_val = bus.rs2_data;
`ifdef DECODE_WB_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd == bus.rs1)
      rs1_val = bus.wb_data;
    if (bus.wb_valid && bus.wb_rd == bus.rs2)
      rs2_val = bus.wb_data;
`endif
  end

  always_comb begin
    fmt    = fmt_of(opc);
    use_rs = rs_use(opc);
    imm    = imm_of(instr, fmt);
    dec    = '0;
    unique case (1'b1)
      opc == OPC_AUIPC,
      opc == OPC_JAL,
      opc == OPC_JALR: dec.opA = CORE_XLEN'(bus.f_pc);
      opc == OPC_LUI:  dec.opA = '0;
      default:         dec.opA = CORE_XLEN'(rs1_val);
    endcase
    dec.opB = (opc == OPC_RR) ? CORE_XLEN'(rs2_val)
                              : CORE_XLEN'($signed(imm));
    if (opc == OPC_RR || opc == OPC_RI) begin
      dec.alu_op.opcode  = f3;
      dec.alu_op.aux_sel = instr[30] &&
        ((opc == OPC_RR && f3 == 3'b000) || f3 == 3'b101);
    end
    dec.rd       = rd;
    dec.rf_wr_en = (fmt == FMT_U || fmt == FMT_J ||
                    fmt == FMT_I || fmt == FMT_R) &&
                   rd != 5'd0;
    dec.pc       = CORE_XLEN'(bus.f_pc);
    dec.illegal  = (fmt == FMT_X);
  end

  assign bus.f_ready = rst_n && !bus.flush && !hazard &&
                       (!bus.x_valid || bus.x_ready);
  assign accept = bus.f_valid && bus.f_ready;
  // Only an entry execute has not taken gives its count back.
  assign kill   = bus.flush && bus.x_valid &&
                  !bus.x_ready && bus.x_rf_wr_en;

  decode_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs1_use  (use_rs.rs1),
    .rs2_use  (use_rs.rs2),
    .rd       (rd),
    .wr_en    (dec.rf_wr_en),
    .accept   (accept),
    .wb_valid (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .kill     (kill),
    .kill_rd  (bus.x_rd),
    .hazard   (hazard)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.x_valid    <= 1'b0;
      bus.x_opA      <= '0;
      bus.x_opB      <= '0;
      bus.x_alu_op   <= '0;
      bus.x_rd       <= '0;
      bus.x_rf_wr_en <= 1'b0;
      bus.x_pc       <= '0;
      bus.x_illegal  <= 1'b0;
    end else if (accept) begin
      bus.x_valid    <= 1'b1;
      bus.x_opA      <= XLEN'(dec.opA);
      bus.x_opB      <= XLEN'(dec.opB);
      bus.x_alu_op   <= dec.alu_op;
      bus.x_rd       <= dec.rd;
      bus.x_rf_wr_en <= dec.rf_wr_en;
      bus.x_pc       <= XLEN'(dec.pc);
      bus.x_illegal  <= dec.illegal;
    end else if (bus.x_ready || bus.flush) begin
      bus.x_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: stream, RAW, WAW, backpressure,
// flush, illegal, immediates and reset-while-stalled.
module tb_decode_issue;
  import core_types_pkg::*;

  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ADDI2  = 32'h0070_0113;
  localparam logic [31:0] ADD3   = 32'h0010_81B3;
  localparam logic [31:0] LUI5   = 32'h1234_52B7;
  localparam logic [31:0] ADDI4  = 32'h0010_0213;
  localparam logic [31:0] ILL6   = 32'h0000_037F;
  localparam logic [31:0] SRAI8  = 32'h4034_D413;
  localparam logic [31:0] AUIPC9 = 32'h0000_1497;
  localparam logic [31:0] ADDI0  = 32'h0030_0013;
  localparam logic [31:0] ADDI10 = 32'h0002_8513;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_issue_if #(.XLEN(32)) bus ();

  decode_issue #(
    .XLEN(32), .NUM_REGS(32), .MAX_INFLIGHT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.f_valid  = 1'b0;
    bus.f_instr  = '0;
    bus.f_pc     = '0;
    bus.rs1_data = 32'h11;
    bus.rs2_data = 32'h22;
    bus.x_ready  = 1'b1;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.flush    = 1'b0;

    cyc(); cyc();
    chk("rst_f_ready", 32'(bus.f_ready), 0);
    chk("rst_x_valid", 32'(bus.x_valid), 0);
    chk("rst_x_opA", bus.x_opA, 0);
    chk("rst_x_illegal", 32'(bus.x_illegal), 0);
    chk("rst_x_rd", 32'(bus.x_rd), 0);
    chk("rst_cnt1", 32'(dut.u_sb.cnt[1]), 0);
    rst_n = 1'b1;
    settle();
    chk("post_rst_f_ready", 32'(bus.f_ready), 1);

    // independent stream
    bus.f_valid = 1'b1;
    bus.f_instr = ADDI1;
    bus.f_pc    = 32'h0;
    cyc();
    bus.f_instr = ADDI2;
    bus.f_pc    = 32'h4;
    chk("s1_x_valid", 32'(bus.x_valid), 1);
    chk("s1_x_opB", bus.x_opB, 5);
    chk("s1_x_rd", 32'(bus.x_rd), 1);
    chk("s1_wr_en", 32'(bus.x_rf_wr_en), 1);
    chk("s1_cnt1", 32'(dut.u_sb.cnt[1]), 1);
    cyc();
    bus.f_valid = 1'b0;
    chk("s2_x_valid", 32'(bus.x_valid), 1);
    chk("s2_x_opB", bus.x_opB, 7);
    chk("s2_x_pc", bus.x_pc, 4);
    chk("s2_cnt2", 32'(dut.u_sb.cnt[2]), 1);
    cyc();
    chk("s3_drain", 32'(bus.x_valid), 0);

    // RAW on x1
    bus.f_valid = 1'b1;
    bus.f_instr = ADD3;
    bus.f_pc    = 32'h8;
    settle();
    chk("raw_stall0", 32'(bus.f_ready), 0);
    cyc();
    chk("raw_stall1", 32'(bus.f_ready), 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'h2A;
    settle();
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_wb_cycle", 32'(bus.f_ready), 1);
`else
    chk("raw_wb_cycle", 32'(bus.f_ready), 0);
`endif
    cyc();
    bus.wb_valid = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
    settle();
    chk("raw_after_wb", 32'(bus.f_ready), 1);
    cyc();
`endif
    bus.f_valid = 1'b0;
    chk("raw_x_valid", 32'(bus.x_valid), 1);
    chk("raw_x_rd", 32'(bus.x_rd), 3);
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_x_opA", bus.x_opA, 32'h2A);
    chk("raw_x_opB", bus.x_opB, 32'h2A);
`else
    chk("raw_x_opA", bus.x_opA, 32'h11);
    chk("raw_x_opB", bus.x_opB, 32'h22);
`endif
    chk("raw_alu_op", 32'(bus.x_alu_op), 0);
    chk("raw_cnt1", 32'(dut.u_sb.cnt[1]), 0);
    chk("raw_cnt3", 32'(dut.u_sb.cnt[3]), 1);

    // WAW limit on x5
    bus.f_valid = 1'b1;
    bus.f_instr = LUI5;
    bus.f_pc    = 32'h20;
    settle();
    chk("waw_first", 32'(bus.f_ready), 1);
    cyc(); cyc(); cyc();
    chk("waw_stall", 32'(bus.f_ready), 0);
    chk("waw_cnt5_full", 32'(dut.u_sb.cnt[5]), 3);
    cyc();
    chk("waw_stall2", 32'(bus.f_ready), 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    settle();
    chk("waw_wb_cycle", 32'(bus.f_ready), 0);
    cyc();
    bus.wb_valid = 1'b0;
    settle();
    chk("waw_cnt5_wb", 32'(dut.u_sb.cnt[5]), 2);
    chk("waw_release", 32'(bus.f_ready), 1);
    cyc();
    bus.f_valid = 1'b0;
    chk("waw_cnt5_again", 32'(dut.u_sb.cnt[5]), 3);
    chk("lui_opA", bus.x_opA, 0);
    chk("lui_opB", bus.x_opB, 32'h1234_5000);

    // backpressure
    bus.f_valid = 1'b1;
    bus.f_instr = ADDI4;
    bus.f_pc    = 32'h40;
    cyc();
    bus.x_ready = 1'b0;
    bus.f_pc    = 32'h44;
    settle();
    chk("bp_f_ready", 32'(bus.f_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_x_valid", 32'(bus.x_valid), 1);
      chk("bp_x_pc", bus.x_pc, 32'h40);
      chk("bp_x_opB", bus.x_opB, 1);
      chk("bp_f_ready_hold", 32'(bus.f_ready), 0);
    end
    bus.x_ready = 1'b1;
    settle();
    chk("bp_release", 32'(bus.f_ready), 1);
    cyc();
    bus.f_valid = 1'b0;
    bus.x_ready = 1'b0;
    chk("bp_next_pc", bus.x_pc, 32'h44);
    chk("bp_cnt4", 32'(dut.u_sb.cnt[4]), 2);

    // flush + writeback of x4 in the same cycle
    bus.flush    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    settle();
    chk("fl_f_ready", 32'(bus.f_ready), 0);
    cyc();
    bus.flush    = 1'b0;
    bus.wb_valid = 1'b0;
    chk("fl_x_valid", 32'(bus.x_valid), 0);
    chk("fl_cnt4", 32'(dut.u_sb.cnt[4]), 0);

    // illegal opcode, then SRAI / AUIPC / rd = x0
    bus.x_ready = 1'b1;
    bus.f_valid = 1'b1;
    bus.f_instr = ILL6;
    bus.f_pc    = 32'h50;
    cyc();
    bus.f_instr = SRAI8;
    bus.f_pc    = 32'h58;
    chk("ill_x_valid", 32'(bus.x_valid), 1);
    chk("ill_flag", 32'(bus.x_illegal), 1);
    chk("ill_wr_en", 32'(bus.x_rf_wr_en), 0);
    chk("ill_cnt6", 32'(dut.u_sb.cnt[6]), 0);
    cyc();
    bus.f_instr = AUIPC9;
    bus.f_pc    = 32'h60;
    chk("srai_alu_op", 32'(bus.x_alu_op), 32'hB);
    chk("srai_opB", bus.x_opB, 32'h403);
    chk("srai_opA", bus.x_opA, 32'h11);
    chk("srai_legal", 32'(bus.x_illegal), 0);
    chk("srai_cnt8", 32'(dut.u_sb.cnt[8]), 1);
    cyc();
    bus.f_instr = ADDI0;
    chk("auipc_opA", bus.x_opA, 32'h60);
    chk("auipc_opB", bus.x_opB, 32'h1000);
    chk("auipc_alu_op", 32'(bus.x_alu_op), 0);
    cyc();
    bus.f_valid = 1'b0;
    chk("x0_wr_en", 32'(bus.x_rf_wr_en), 0);
    chk("x0_rd", 32'(bus.x_rd), 0);
    chk("x0_cnt0", 32'(dut.u_sb.cnt[0]), 0);

    // reset while stalled on x5
    bus.f_valid = 1'b1;
    bus.f_instr = ADDI10;
    bus.f_pc    = 32'h70;
    settle();
    chk("rs_stall", 32'(bus.f_ready), 0);
    rst_n = 1'b0;
    settle();
    chk("rs_f_ready_rst", 32'(bus.f_ready), 0);
    cyc();
    chk("rs_x_valid", 32'(bus.x_valid), 0);
    chk("rs_x_opB", bus.x_opB, 0);
    chk("rs_cnt5", 32'(dut.u_sb.cnt[5]), 0);
    rst_n = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    settle();
    chk("rs_ready", 32'(bus.f_ready), 1);
    cyc();
    bus.wb_valid = 1'b0;
    bus.f_valid  = 1'b0;
    chk("rs_cnt5_floor", 32'(dut.u_sb.cnt[5]), 0);
    chk("rs_x_rd", 32'(bus.x_rd), 10);
    chk("rs_cnt10", 32'(dut.u_sb.cnt[10]), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
